// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution write/read sequencers.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    localparam logic [2:0] WRITE_STATE_CODE = 3'd4;

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_beat_counter.sv
// Two-level (element, channel) wrapping beat counter with clear, enable and last-beat flag.
module conv_beat_counter
    import conv_pkg::*;
#(
    parameter  int COUNT_SEL = 8,
    parameter  int COUNT_CH  = 1,
    localparam int SEL_W     = idx_width(COUNT_SEL),
    localparam int CH_W      = idx_width(COUNT_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] sel,
    output logic [CH_W-1:0]  ch,
    output logic [SEL_W-1:0] sel_nxt,
    output logic [CH_W-1:0]  ch_nxt,
    output logic             last
);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             sel_max, ch_max;

    assign sel_max = (sel_q == SEL_W'(COUNT_SEL - 1));
    assign ch_max  = (ch_q == CH_W'(COUNT_CH - 1));

    always_comb begin
        sel_d = sel_q;
        ch_d  = ch_q;
        if (clr) begin
            sel_d = '0;
            ch_d  = '0;
        end else if (en) begin
            if (sel_max) begin
                sel_d = '0;
                ch_d  = ch_max ? '0 : ch_q + 1'b1;
            end else begin
                sel_d = sel_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            ch_q  <= '0;
        end else begin
            sel_q <= sel_d;
            ch_q  <= ch_d;
        end
    end

    assign sel     = sel_q;
    assign ch      = ch_q;
    assign sel_nxt = sel_d;
    assign ch_nxt  = ch_d;
    assign last    = sel_max && ch_max;

endmodule

// File: rtl/conv_write_seq.sv
// Write-back sequencer: snapshots one PE tile and streams it out beat by beat
// with valid/ready handshake, linear write address and optional ReLU.
module conv_write_seq
    import conv_pkg::*;
#(
    parameter  int         DATA_WIDTH  = 16,
    parameter  int         TILING_SIZE = 8,
    parameter  int         NUM_CH      = 1,
    parameter  int         ADDR_WIDTH  = 16,
    parameter  logic [2:0] WRITE_STATE = WRITE_STATE_CODE,
    parameter  int         SKIP_TILES  = 1,
    localparam int         SEL_W       = idx_width(TILING_SIZE),
    localparam int         CH_W        = idx_width(NUM_CH),
    localparam int         TILE_W      = NUM_CH * TILING_SIZE * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            state,
    input  logic [31:0]           counter_tiling,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  relu_en,
    input  logic [TILE_W-1:0]     data_in,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_output,
    output logic                  valid_data,
    output logic [SEL_W-1:0]      sel_data,
    output logic [CH_W-1:0]       ch_sel,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  busy,
    output logic                  done
);

    seq_state_e            fsm_q, fsm_d;
    logic [2:0]            prev_state_q;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  relu_q, relu_d;
    logic [TILE_W-1:0]     snap_q, snap_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  trigger, xfer, last_beat;
    logic [SEL_W-1:0]      sel_cur, sel_nxt;
    logic [CH_W-1:0]       ch_cur, ch_nxt;
    logic [TILE_W-1:0]     elem_src;
    logic [DATA_WIDTH-1:0] elem, elem_relu;

    assign trigger = (state == WRITE_STATE) && (prev_state_q != WRITE_STATE)
                     && (counter_tiling > 32'(SKIP_TILES));
    assign xfer    = (fsm_q == ST_WRITE) && valid_q && out_ready;

    conv_beat_counter #(
        .COUNT_SEL (TILING_SIZE),
        .COUNT_CH  (NUM_CH)
    ) u_beat_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (fsm_q != ST_WRITE),
        .en      (xfer),
        .sel     (sel_cur),
        .ch      (ch_cur),
        .sel_nxt (sel_nxt),
        .ch_nxt  (ch_nxt),
        .last    (last_beat)
    );

    // Beat 0 comes straight from data_in while the snapshot is being loaded.
    assign elem_src = (fsm_q == ST_CAPTURE) ? data_in : snap_q;

    always_comb begin
        elem = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < TILING_SIZE; s++) begin
                if ((ch_nxt == CH_W'(c)) && (sel_nxt == SEL_W'(s))) begin
                    elem = elem_src[(c * TILING_SIZE + s) * DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign elem_relu = (relu_q && elem[DATA_WIDTH-1]) ? '0 : elem;

    always_comb begin
        fsm_d   = fsm_q;
        base_d  = base_q;
        relu_d  = relu_q;
        snap_d  = snap_q;
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                data_d  = '0;
                addr_d  = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (trigger) begin
                    fsm_d  = ST_CAPTURE;
                    base_d = base_addr;
                    relu_d = relu_en;
                    busy_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                fsm_d   = ST_WRITE;
                snap_d  = data_in;
                valid_d = 1'b1;
                data_d  = elem_relu;
                addr_d  = base_q;
            end
            ST_WRITE: begin
                if (xfer) begin
                    if (last_beat) begin
                        fsm_d   = ST_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        data_d  = '0;
                        addr_d  = '0;
                    end else begin
                        data_d = elem_relu;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q        <= ST_IDLE;
            prev_state_q <= '0;
            base_q       <= '0;
            relu_q       <= 1'b0;
            snap_q       <= '0;
            data_q       <= '0;
            addr_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            prev_state_q <= state;
            base_q       <= base_d;
            relu_q       <= relu_d;
            snap_q       <= snap_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign data_output = data_q;
    assign valid_data  = valid_q;
    assign sel_data    = sel_cur;
    assign ch_sel      = ch_cur;
    assign wr_addr     = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_conv_write_seq.sv
// Scoreboard bench for conv_write_seq with an 8x2 tile of 16-bit elements.
module tb_conv_write_seq;

    localparam int DW = 16;
    localparam int TS = 8;
    localparam int NC = 2;
    localparam int AW = 16;
    localparam int NB = TS * NC;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [2:0]    sel;
        logic          ch;
        logic [AW-1:0] addr;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        state;
    logic [31:0]       counter_tiling;
    logic [AW-1:0]     base_addr;
    logic              relu_en;
    logic [NB*DW-1:0]  data_in;
    logic              out_ready;
    logic [DW-1:0]     data_output;
    logic              valid_data;
    logic [2:0]        sel_data;
    logic              ch_sel;
    logic [AW-1:0]     wr_addr;
    logic              busy;
    logic              done;

    beat_t         exp_q[$];
    logic [DW-1:0] tile[NB];
    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    int            xfer_cnt = 0;
    int            ready_mode = 0;
    bit            busy_seen = 0;
    bit            hold_pend = 0;
    beat_t         held;

    conv_write_seq #(
        .DATA_WIDTH  (DW),
        .TILING_SIZE (TS),
        .NUM_CH      (NC),
        .ADDR_WIDTH  (AW),
        .WRITE_STATE (3'd4),
        .SKIP_TILES  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .state          (state),
        .counter_tiling (counter_tiling),
        .base_addr      (base_addr),
        .relu_en        (relu_en),
        .data_in        (data_in),
        .out_ready      (out_ready),
        .data_output    (data_output),
        .valid_data     (valid_data),
        .sel_data       (sel_data),
        .ch_sel         (ch_sel),
        .wr_addr        (wr_addr),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat.
    always @(negedge clk) begin
        beat_t cur, e;
        cur = '{data: data_output, sel: sel_data, ch: ch_sel, addr: wr_addr};
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (busy || valid_data) busy_seen = 1'b1;
            if (hold_pend && valid_data) check("hold_stable", cur, held);
            hold_pend = 1'b0;
            if (valid_data) begin
                if (out_ready) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", cur, '0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", cur.data, e.data);
                        check("beat_sel", cur.sel, e.sel);
                        check("beat_ch", cur.ch, e.ch);
                        check("beat_addr", cur.addr, e.addr);
                    end
                end else begin
                    hold_pend = 1'b1;
                    held = cur;
                end
            end
        end
    end

    // Ready driver: mode 0 always ready, mode 1 repeats 1,0,0.
    initial begin
        int rcnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
            rcnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // mode 0: plain burst, 1: state drops and re-rises mid-burst, 2: reset at beat 5
    task automatic run_burst(input logic [AW-1:0] base, input bit relu, input bit scramble, input int mode);
        int  d0, x0;
        bit  finished;
        beat_t b;
        for (int i = 0; i < NB; i++) data_in[i*DW +: DW] = tile[i];
        base_addr      = base;
        relu_en        = relu;
        counter_tiling = 32'd2;
        for (int c = 0; c < NC; c++) begin
            for (int s = 0; s < TS; s++) begin
                b.data = (relu && tile[c*TS+s][DW-1]) ? '0 : tile[c*TS+s];
                b.sel  = 3'(s);
                b.ch   = 1'(c);
                b.addr = base + AW'(c*TS + s);
                exp_q.push_back(b);
            end
        end
        d0 = done_cnt;
        x0 = xfer_cnt;
        @(posedge clk); #1;
        state = 3'd4;
        @(posedge clk); #1;
        check("trig_busy", busy, 1'b1);
        check("trig_valid_low", valid_data, 1'b0);
        @(posedge clk); #1;
        check("valid_rise", valid_data, 1'b1);
        if (scramble) begin
            for (int i = 0; i < NB; i++) data_in[i*DW +: DW] = DW'($urandom);
        end
        finished = 1'b0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(posedge clk); #1;
            if (mode == 1 && (xfer_cnt - x0) == 3) state = 3'd0;
            if (mode == 1 && (xfer_cnt - x0) == 6) state = 3'd4;
            if (mode == 2 && (xfer_cnt - x0) == 5) begin
                rst = 1'b1;
                state = 3'd0;
                #1;
                check("rst_abort_outputs",
                      {data_output, valid_data, sel_data, ch_sel, wr_addr, busy, done}, '0);
                exp_q.delete();
                d0 = done_cnt;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                check("rst_no_done", done_cnt - d0, 0);
                check("rst_idle_busy", busy, 1'b0);
                return;
            end
            if (done_cnt != d0) finished = 1'b1;
        end
        if (!finished) check("done_timeout", 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("beat_total", xfer_cnt - x0, NB);
        check("scoreboard_empty", exp_q.size(), 0);
        check("idle_outputs", {data_output, valid_data, sel_data, ch_sel, busy, done}, '0);
        state = 3'd0;
        @(posedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        state          = 3'd0;
        counter_tiling = 32'd0;
        base_addr      = '0;
        relu_en        = 1'b0;
        data_in        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {data_output, valid_data, sel_data, ch_sel, wr_addr, busy, done}, '0);
        rst = 1'b0;
        @(posedge clk);

        // basic burst, consecutive addresses 0x0100..0x010F
        for (int i = 0; i < NB; i++) tile[i] = 16'h0010 + DW'(i * 16'h0111);
        run_burst(16'h0100, 1'b0, 1'b0, 0);

        // counter_tiling not above skip threshold, then no new edge
        busy_seen = 1'b0;
        counter_tiling = 32'd1;
        #1 state = 3'd4;
        repeat (8) @(posedge clk);
        check("skip_low_tile", busy_seen, 1'b0);
        counter_tiling = 32'd2;
        repeat (8) @(posedge clk);
        check("skip_no_edge", busy_seen, 1'b0);
        state = 3'd0;
        repeat (2) @(posedge clk);

        // backpressure with negative elements, ReLU off
        ready_mode = 1;
        for (int i = 0; i < NB; i++) tile[i] = 16'h8001 + DW'(i * 16'h1357);
        run_burst(16'h0200, 1'b0, 1'b0, 0);
        ready_mode = 0;

        // ReLU on, data_in scrambled after capture
        for (int i = 0; i < NB; i++) tile[i] = (i % 2 == 1) ? DW'(16'h7000 + i) : DW'(16'hF000 + i);
        tile[0] = 16'hFFF0;
        tile[1] = 16'h0005;
        tile[15] = 16'h8000;
        run_burst(16'h0300, 1'b1, 1'b1, 0);

        // address wrap through zero, with backpressure
        ready_mode = 1;
        for (int i = 0; i < NB; i++) tile[i] = DW'(16'hA5A0 ^ i);
        run_burst(16'hFFFC, 1'b0, 1'b0, 0);
        ready_mode = 0;

        // reset at beat 5, then a fresh burst from (0,0)
        for (int i = 0; i < NB; i++) tile[i] = DW'(16'h0300 + i);
        run_burst(16'h0040, 1'b0, 1'b0, 2);
        run_burst(16'h0040, 1'b0, 1'b0, 0);

        // state drops and re-rises mid-burst: completes once, no re-trigger
        for (int i = 0; i < NB; i++) tile[i] = DW'(16'h1234 + i * 3);
        run_burst(16'h0500, 1'b0, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_write_seq.md
Name: conv_write_seq

Overview:
Parametrised write-back sequencer for the convolution datapath. When the top-level controller enters its write state, it snapshots one tile of PE results (TILING_SIZE elements × NUM_CH channels). It then streams the tile out one element per beat, with a valid/ready handshake, a generated write address and optional ReLU. It sits between the PE array output registers and the output-feature-map buffer, and adds multi-channel, backpressure and address generation.

Parameters:
DATA_WIDTH, 16, element width (signed two's complement)
TILING_SIZE, 8, elements per channel per tile (>=2)
NUM_CH, 1, output channels per tile (>=1)
ADDR_WIDTH, 16, write address width
WRITE_STATE, 3'd4, top-level state code that triggers a burst
SKIP_TILES, 1, burst fires only when counter_tiling > SKIP_TILES

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
state  in  3  top-level controller state
counter_tiling  in  32  current tile counter
base_addr  in  ADDR_WIDTH  address of beat 0, sampled at trigger
relu_en  in  1  ReLU mode, sampled at trigger
data_in  in  NUM_CH*TILING_SIZE*DATA_WIDTH  packed tile; element (c,s) at bits [(c*TILING_SIZE+s)*DATA_WIDTH +: DATA_WIDTH]
out_ready  in  1  downstream accepts beat
data_output  out  DATA_WIDTH  current beat data
valid_data  out  1  beat valid
sel_data  out  max(1,clog2(TILING_SIZE))  element index of current beat
ch_sel  out  max(1,clog2(NUM_CH))  channel index of current beat
wr_addr  out  ADDR_WIDTH  write address of current beat
busy  out  1  burst in progress (CAPTURE or WRITE)
done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (async, rst=1): FSM=IDLE. Every output is 0. Snapshot, counters and edge register are cleared. A reset mid-burst aborts the burst, and no done is issued.
- Trigger = (state==WRITE_STATE) && (prev_state!=WRITE_STATE) && (counter_tiling > SKIP_TILES), sampled in IDLE. prev_state is a registered copy of state, updated every cycle in every FSM state. Holding state at WRITE_STATE produces exactly one burst.
- FSM states: IDLE, CAPTURE, WRITE, DONE.
- IDLE -> CAPTURE on trigger. On that edge, latch base_addr and relu_en and set busy=1.
- CAPTURE -> WRITE unconditionally. On that edge: snapshot data_in, set valid_data=1 and drive beat (0,0). valid_data therefore rises 2 cycles after the trigger edge. data_in may change freely after this edge.
- WRITE: a beat transfers on a rising edge where valid_data && out_ready.
  - Beat order: sel_data advances 0..TILING_SIZE-1, wraps to 0 and increments ch_sel.
  - No transfer: data_output, sel_data, ch_sel and wr_addr hold, and valid_data stays 1.
  - Transfer of the last beat (ch=NUM_CH-1, sel=TILING_SIZE-1): go to DONE, with valid_data=0 and busy=0 on the same edge.
- DONE: done=1 for exactly one cycle, then IDLE. Outputs sel_data, ch_sel and data_output return to 0 in IDLE.
- Beat outputs are all registered:
  - data_output = snapshot(ch,sel); when the latched relu_en=1 and the element MSB=1, data_output=0.
  - wr_addr = latched base_addr + ch*TILING_SIZE + sel, modulo 2^ADDR_WIDTH (wraps, no error).
- state leaving WRITE_STATE mid-burst: the burst still completes. A new WRITE_STATE edge during busy or DONE is ignored (not queued).
- Total beats per burst = NUM_CH*TILING_SIZE. Minimum burst length with out_ready=1 = 2 + NUM_CH*TILING_SIZE cycles from the trigger edge to the done pulse.

Decomposition:
- Shared package conv_pkg:
  - FSM state encoding localparams (IDLE/CAPTURE/WRITE/DONE).
  - Top-level state code constant (WRITE_STATE=3'd4).
  - Width helper function for the index widths.
- One natural sub-module: conv_beat_counter, a 2-level (sel, ch) wrapping counter with enable and last-beat flag. It is reusable by the read-side sequencer.
- Element mux and ReLU stay inline.

Test Plan:
- TILING_SIZE=8, NUM_CH=2, base_addr=0x0100, counter_tiling=2, out_ready=1, state 0->4 -> valid rises 2 cycles later; 16 consecutive beats with wr_addr 0x0100..0x010F and (ch,sel) = (0,0)..(1,7), data matching the snapshot; exactly one done pulse.
- counter_tiling=1 with state 0->4 -> no valid, busy stays 0. Then counter_tiling=2 with state still 4 -> still no burst (no edge).
- out_ready toggled 1,0,0,1,... -> each beat held stable while ready=0; no beat skipped or duplicated; 16 transfers total.
- relu_en=1, snapshot elements 16'hFFF0, 16'h0005 -> outputs 0x0000, 0x0005. Change data_in after CAPTURE -> outputs unaffected.
- base_addr=0xFFFC, 8 beats -> wr_addr 0xFFFC..0xFFFF, then 0x0000..0x0003.
- rst asserted at beat 5 -> all outputs 0 immediately, no done. After release, state 0->4 -> a fresh burst starting at beat (0,0). Second test: state 4->0 mid-burst -> burst completes, done pulses once.
